// File: rtl/adc_dac_router.sv
// ADC-to-DAC sample router: 3-stage format/route/gain pipeline with sticky saturation
// flags, plus a triggered capture buffer that snoops one DAC channel.
module adc_dac_router #(
  parameter  int N_CH      = 2,
  parameter  int ADC_W     = 12,
  parameter  int DAC_W     = 14,
  parameter  int CAP_DEPTH = 16,
  localparam int AW        = $clog2(CAP_DEPTH),
  localparam int SW        = $clog2(N_CH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_CH*ADC_W-1:0] adc_data,
  input  logic                  adc_valid,
  input  logic                  cfg_fmt_in,
  input  logic                  cfg_fmt_out,
  input  logic [N_CH*SW-1:0]    cfg_src_sel,
  input  logic [N_CH*3-1:0]     cfg_gain,
  input  logic [N_CH-1:0]       cfg_mute,
  output logic [N_CH*DAC_W-1:0] dac_data,
  output logic                  dac_valid,
  output logic [N_CH-1:0]       sat_flag,
  input  logic                  sat_clr,
  input  logic                  cap_arm,
  input  logic                  cap_trig,
  input  logic [SW-1:0]         cap_ch,
  output logic                  cap_busy,
  output logic                  cap_done,
  input  logic [AW-1:0]         cap_rd_addr,
  output logic [DAC_W-1:0]      cap_rd_data
);

  localparam int LJ = DAC_W - ADC_W;
  localparam int WW = DAC_W + 8;
  localparam logic signed [WW-1:0] P_MAX = {{(WW-DAC_W+1){1'b0}}, {(DAC_W-1){1'b1}}};
  localparam logic signed [WW-1:0] P_MIN = {{(WW-DAC_W+1){1'b1}}, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } cap_state_t;

  logic signed [ADC_W-1:0] r_s1 [N_CH];
  logic                    r_s1_vld;
  logic signed [DAC_W-1:0] r_s2 [N_CH];
  logic                    r_s2_vld;
  logic [N_CH*DAC_W-1:0]   r_dac;
  logic                    r_dac_vld;
  logic [N_CH-1:0]         r_sat;

  logic signed [DAC_W-1:0] w_s2_nxt [N_CH];
  logic signed [DAC_W-1:0] w_s3 [N_CH];
  logic [N_CH-1:0]         w_clamp;

  cap_state_t              r_state;
  logic [AW-1:0]           r_waddr;
  logic [SW-1:0]           r_cap_ch;
  logic                    r_cap_trig;
  logic                    r_busy;
  logic                    r_done;
  logic [N_CH-1:0]         r_prev_neg;
  logic [DAC_W-1:0]        r_rd;
  logic [DAC_W-1:0]        r_ram [CAP_DEPTH];

  logic signed [DAC_W-1:0] w_cap_val;
  logic                    w_hit;
  logic                    w_wr_en;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SW-1:0]           w_src;
    logic [2:0]              w_gain;
    logic signed [ADC_W-1:0] w_sel;
    logic signed [DAC_W-1:0] w_lj;
    logic signed [WW-1:0]    w_wide;

    assign w_src       = cfg_src_sel[g*SW +: SW];
    assign w_gain      = cfg_gain[g*3 +: 3];
    assign w_sel       = (int'(w_src) < N_CH) ? r_s1[w_src] : r_s1[0];
    assign w_lj        = DAC_W'(w_sel) <<< LJ;
    assign w_wide      = WW'(w_lj) <<< w_gain;
    assign w_clamp[g]  = (w_wide > P_MAX) || (w_wide < P_MIN);
    assign w_s2_nxt[g] = (w_wide > P_MAX) ? P_MAX[DAC_W-1:0] :
                         (w_wide < P_MIN) ? P_MIN[DAC_W-1:0] : w_wide[DAC_W-1:0];
    // Muting forces signed zero, which becomes mid-scale after offset-binary conversion.
    assign w_s3[g]     = cfg_mute[g] ? '0 : r_s2[g];
  end

  // Stage 1: capture samples and normalise to two's complement.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s1_vld <= 1'b0;
      for (int k = 0; k < N_CH; k++) r_s1[k] <= '0;
    end else begin
      r_s1_vld <= adc_valid;
      if (adc_valid) begin
        for (int k = 0; k < N_CH; k++)
          r_s1[k] <= {adc_data[k*ADC_W + ADC_W - 1] ^ ~cfg_fmt_in, adc_data[k*ADC_W +: (ADC_W-1)]};
      end
    end
  end

  // Stage 2 (route/gain/saturate) and stage 3 (mute/output format), plus sticky flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s2_vld  <= 1'b0;
      r_dac_vld <= 1'b0;
      r_dac     <= '0;
      r_sat     <= '0;
      for (int k = 0; k < N_CH; k++) r_s2[k] <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_dac_vld <= r_s2_vld;
      r_sat     <= (r_sat & ~{N_CH{sat_clr}}) | (w_clamp & {N_CH{r_s1_vld}});
      if (r_s1_vld) begin
        for (int k = 0; k < N_CH; k++) r_s2[k] <= w_s2_nxt[k];
      end
      if (r_s2_vld) begin
        for (int k = 0; k < N_CH; k++)
          r_dac[k*DAC_W +: DAC_W] <= {w_s3[k][DAC_W-1] ^ ~cfg_fmt_out, w_s3[k][DAC_W-2:0]};
      end
    end
  end

  assign w_cap_val = w_s3[r_cap_ch];
  assign w_hit     = ~r_cap_trig | (~w_cap_val[DAC_W-1] & r_prev_neg[r_cap_ch]);
  // The write address is held at 0 while armed, so one address feeds both states.
  assign w_wr_en   = r_s2_vld & (((r_state == S_ARMED) & w_hit) | (r_state == S_FILL));

  // Capture control FSM.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_cap_ch   <= '0;
      r_cap_trig <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_prev_neg <= '0;
    end else begin
      if (r_s2_vld) begin
        for (int k = 0; k < N_CH; k++) r_prev_neg[k] <= w_s3[k][DAC_W-1];
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (cap_arm) begin
            r_state    <= S_ARMED;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_waddr    <= '0;
            r_cap_ch   <= (int'(cap_ch) < N_CH) ? cap_ch : '0;
            r_cap_trig <= cap_trig;
          end
        end
        S_ARMED: begin
          if (r_s2_vld && w_hit) begin
            r_state <= S_FILL;
            r_waddr <= AW'(1);
          end
        end
        S_FILL: begin
          if (r_s2_vld) begin
            if (r_waddr == AW'(CAP_DEPTH-1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_waddr <= r_waddr + AW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Capture storage keeps its contents across reset.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_ram[r_waddr] <= w_cap_val;
  end

  // Registered read port.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_rd <= '0;
    else         r_rd <= r_ram[cap_rd_addr];
  end

  assign dac_data    = r_dac;
  assign dac_valid   = r_dac_vld;
  assign sat_flag    = r_sat;
  assign cap_busy    = r_busy;
  assign cap_done    = r_done;
  assign cap_rd_data = r_rd;

endmodule

// File: tb/tb_adc_dac_router.sv
// Bench for adc_dac_router: behavioural reference model checked every cycle, plus
// directed cases with hand-computed values.
module tb_adc_dac_router;
  localparam int N_CH = 2;
  localparam int ADC_W = 12;
  localparam int DAC_W = 14;
  localparam int CAP_DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] adc_data = 24'd0;
  logic        adc_valid = 1'b0;
  logic        cfg_fmt_in = 1'b0;
  logic        cfg_fmt_out = 1'b0;
  logic [1:0]  cfg_src_sel = 2'b10;
  logic [5:0]  cfg_gain = 6'd0;
  logic [1:0]  cfg_mute = 2'b00;
  logic [27:0] dac_data;
  logic        dac_valid;
  logic [1:0]  sat_flag;
  logic        sat_clr = 1'b0;
  logic        cap_arm = 1'b0;
  logic        cap_trig = 1'b0;
  logic [0:0]  cap_ch = 1'b0;
  logic        cap_busy;
  logic        cap_done;
  logic [3:0]  cap_rd_addr = 4'd0;
  logic [13:0] cap_rd_data;

  adc_dac_router dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_fmt_in(cfg_fmt_in), .cfg_fmt_out(cfg_fmt_out), .cfg_src_sel(cfg_src_sel),
    .cfg_gain(cfg_gain), .cfg_mute(cfg_mute), .dac_data(dac_data), .dac_valid(dac_valid),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .cap_arm(cap_arm), .cap_trig(cap_trig),
    .cap_ch(cap_ch), .cap_busy(cap_busy), .cap_done(cap_done),
    .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int conv_in(input logic [11:0] x, input bit fi);
    return fi ? int'($signed(x)) : int'(x) - 2048;
  endfunction

  function automatic int route(input logic [23:0] d, input bit fi, input logic [1:0] src,
                               input logic [5:0] gain, input int j, output bit clamped);
    int s_ch, v;
    s_ch = int'(src[j]);
    if (s_ch >= N_CH) s_ch = 0;
    v = conv_in(d[s_ch*12 +: 12], fi) * 4 * (1 << gain[j*3 +: 3]);
    clamped = (v > 8191) || (v < -8192);
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  logic [23:0] h_data [4];
  bit          h_valid [4] = '{0, 0, 0, 0};
  bit          h_fi [4];
  logic [1:0]  h_src [4];
  logic [5:0]  h_gain [4];
  int          k = 0;
  bit          m_dv = 0;
  int          m_dac [2] = '{0, 0};
  int          m_s3 [2] = '{0, 0};
  logic [1:0]  m_sat = 2'b00;
  int          m_mode = 0;   // 0 idle, 1 armed, 2 fill, 3 done
  int          m_wa = 0;
  int          m_cch = 0;
  bit          m_ctrig = 0;
  bit          m_prev [2] = '{0, 0};
  int          m_ram [16];
  bit          m_known [16];

  initial begin : compare_proc
    int i0, i1, i2, a, v, oldv, newv;
    bit cl, ok_old, ok_new, hit;
    logic [1:0] set_s;
    for (int q = 0; q < 16; q++) begin m_known[q] = 0; m_ram[q] = 0; end
    forever begin
      @(posedge sys_clk);
      i0 = k % 4; i1 = (k + 3) % 4; i2 = (k + 2) % 4;
      h_valid[i0] = adc_valid; h_data[i0] = adc_data; h_fi[i0] = cfg_fmt_in;
      h_src[i0] = cfg_src_sel; h_gain[i0] = cfg_gain;
      a = int'(cap_rd_addr);
      if (sys_rst) begin
        for (int q = 0; q < 4; q++) h_valid[q] = 0;
        m_dv = 0; m_dac = '{0, 0}; m_sat = 2'b00; m_mode = 0; m_wa = 0;
        m_prev = '{0, 0}; ok_old = 1; ok_new = 1; oldv = 0; newv = 0;
      end else begin
        set_s = 2'b00;
        for (int j = 0; j < 2; j++) begin
          v = route(h_data[i1], h_fi[i1], cfg_src_sel, cfg_gain, j, cl);
          set_s[j] = h_valid[i1] & cl;
        end
        m_sat = (m_sat & ~{2{sat_clr}}) | set_s;
        m_dv = h_valid[i2];
        if (m_dv) begin
          for (int j = 0; j < 2; j++) begin
            v = route(h_data[i2], h_fi[i2], h_src[i1], h_gain[i1], j, cl);
            m_s3[j] = cfg_mute[j] ? 0 : v;
            m_dac[j] = cfg_fmt_out ? (m_s3[j] & 'h3FFF) : ((m_s3[j] + 8192) & 'h3FFF);
          end
        end
        ok_old = m_known[a]; oldv = m_ram[a];
        if ((m_mode == 0 || m_mode == 3) && cap_arm) begin
          m_mode = 1; m_cch = int'(cap_ch); m_ctrig = cap_trig; m_wa = 0;
        end else if (m_mode == 1 && m_dv) begin
          hit = !m_ctrig || (m_s3[m_cch] >= 0 && m_prev[m_cch]);
          if (hit) begin
            m_ram[0] = m_s3[m_cch]; m_known[0] = 1; m_wa = 1; m_mode = 2;
          end
        end else if (m_mode == 2 && m_dv) begin
          m_ram[m_wa] = m_s3[m_cch]; m_known[m_wa] = 1;
          if (m_wa == CAP_DEPTH - 1) m_mode = 3;
          else m_wa++;
        end
        if (m_dv) for (int j = 0; j < 2; j++) m_prev[j] = (m_s3[j] < 0);
        ok_new = m_known[a]; newv = m_ram[a];
      end
      #1;
      check("dac_valid", 32'(dac_valid), 32'(m_dv));
      check("dac0", 32'(dac_data[13:0]), 32'(m_dac[0]));
      check("dac1", 32'(dac_data[27:14]), 32'(m_dac[1]));
      check("sat_flag", 32'(sat_flag), 32'(m_sat));
      check("cap_busy", 32'(cap_busy), 32'(m_mode == 1 || m_mode == 2));
      check("cap_done", 32'(cap_done), 32'(m_mode == 3));
      if (ok_old && ok_new) begin
        n_checks++;
        if (32'(cap_rd_data) != 32'(oldv & 'h3FFF) && 32'(cap_rd_data) != 32'(newv & 'h3FFF)) begin
          n_fail++;
          $display("FAIL cap_rd_data: got 0x%0h, expected 0x%0h or 0x%0h at %0t",
                   cap_rd_data, oldv & 'h3FFF, newv & 'h3FFF, $time);
        end
      end
      k++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [11:0] c0, input logic [11:0] c1, input bit v);
    @(negedge sys_clk);
    adc_data = {c1, c0}; adc_valid = v; cap_arm = 1'b0; sat_clr = 1'b0;
  endtask

  task automatic send(input logic [11:0] c0, input logic [11:0] c1);
    drive(c0, c1, 1'b1);
    drive(c0, c1, 1'b0);
    repeat (2) @(posedge sys_clk);
    #2;
  endtask

  int sine [16] = '{293, 834, 1247, 1471, 1471, 1247, 834, 293,
                    -293, -834, -1247, -1471, -1471, -1247, -834, -293};

  initial begin : main
    bit found;
    @(posedge sys_clk); #2;
    check("rst_dac", 32'(dac_data), 32'd0);
    check("rst_valid", 32'(dac_valid), 32'd0);
    check("rst_busy_done", 32'({cap_busy, cap_done}), 32'd0);
    @(negedge sys_clk); sys_rst = 1'b0;

    // offset-binary in, gain 0, both output formats
    cfg_fmt_in = 1'b0; cfg_fmt_out = 1'b0; cfg_gain = 6'd0; cfg_src_sel = 2'b10;
    send(12'hFFF, 12'h000); check("fffe_ob", 32'(dac_data[13:0]), 32'h3FFC);
    cfg_fmt_out = 1'b1;
    send(12'hFFF, 12'h000); check("fff_tc", 32'(dac_data[13:0]), 32'h1FFC);
    send(12'h800, 12'h000); check("800_tc", 32'(dac_data[13:0]), 32'h0000);
    cfg_fmt_out = 1'b0;
    send(12'h800, 12'h000); check("800_ob", 32'(dac_data[13:0]), 32'h2000);

    // saturation with gain 1
    cfg_gain = 6'b000001; cfg_fmt_out = 1'b1;
    send(12'hFFF, 12'h000);
    check("sat_pos", 32'(dac_data[13:0]), 32'h1FFF);
    check("sat_flag0", 32'(sat_flag[0]), 32'd1);
    send(12'h000, 12'h000); check("sat_neg", 32'(dac_data[13:0]), 32'h2000);
    @(negedge sys_clk); sat_clr = 1'b1;
    @(negedge sys_clk); sat_clr = 1'b0;
    check("sat_clr", 32'(sat_flag[0]), 32'd0);

    // cross routing and mute
    cfg_gain = 6'd0; cfg_fmt_out = 1'b0; cfg_src_sel = 2'b01;
    send(12'h100, 12'hF00);
    check("route_dac0", 32'(dac_data[13:0]), 32'h3C00);
    check("route_dac1", 32'(dac_data[27:14]), 32'h0400);
    cfg_mute = 2'b10;
    send(12'h100, 12'hF00); check("mute_dac1", 32'(dac_data[27:14]), 32'h2000);
    cfg_mute = 2'b00;

    // reset mid-stream, then first-valid latency
    cfg_gain = 6'b111111; cfg_src_sel = 2'b10;
    for (int i = 0; i < 4; i++) drive(12'hFFF, 12'hFFF, 1'b1);
    @(negedge sys_clk); sys_rst = 1'b1;
    #1;
    check("mid_rst_dac", 32'(dac_data), 32'd0);
    check("mid_rst_flags", 32'({dac_valid, sat_flag, cap_busy, cap_done}), 32'd0);
    check("mid_rst_rd", 32'(cap_rd_data), 32'd0);
    @(negedge sys_clk); sys_rst = 1'b0; adc_valid = 1'b0; cfg_gain = 6'd0;
    drive(12'h123, 12'h456, 1'b1);
    drive(12'h123, 12'h456, 1'b0);
    @(posedge sys_clk); #2; check("lat_c2", 32'(dac_valid), 32'd0);
    @(posedge sys_clk); #2; check("lat_c3", 32'(dac_valid), 32'd1);

    // immediate capture of a ramp, re-arm during fill ignored
    cfg_fmt_in = 1'b1; cfg_fmt_out = 1'b1; cap_ch = 1'b0;
    @(negedge sys_clk); cap_arm = 1'b1; cap_trig = 1'b0; adc_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(12'(i * 16), 12'h000, 1'b1);
      if (i == 5) cap_arm = 1'b1;
    end
    drive(12'h000, 12'h000, 1'b0);
    repeat (4) @(negedge sys_clk);
    check("ramp_done", 32'(cap_done), 32'd1);
    check("ramp_busy", 32'(cap_busy), 32'd0);
    for (int a = 0; a < 16; a++) begin
      @(negedge sys_clk); cap_rd_addr = 4'(a);
      @(posedge sys_clk); #2;
      check("ramp_rd", 32'(cap_rd_data), 32'(a * 64));
    end

    // zero-crossing capture of a sine, reset at address 7
    @(negedge sys_clk); cap_arm = 1'b1; cap_trig = 1'b1; cap_ch = 1'b0; adc_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      drive(12'(sine[i % 16]), 12'h000, 1'b1);
      if (m_mode == 2 && m_wa == 7) found = 1;
    end
    check("sine_reach_addr7", 32'(found), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("sine_rst_busy", 32'(cap_busy), 32'd0);
    check("sine_rst_done", 32'(cap_done), 32'd0);
    @(negedge sys_clk); sys_rst = 1'b0; adc_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("sine_idle", 32'({cap_busy, cap_done}), 32'd0);
    cap_rd_addr = 4'd0; @(posedge sys_clk); #2;
    check("sine_addr0", 32'(cap_rd_data), 32'(293 * 4));
    @(negedge sys_clk); cap_rd_addr = 4'd6; @(posedge sys_clk); #2;
    check("sine_addr6", 32'(cap_rd_data), 32'(834 * 4));
    @(negedge sys_clk); cap_rd_addr = 4'd7; @(posedge sys_clk); #2;
    check("sine_addr7_old", 32'(cap_rd_data), 32'(7 * 64));

    // randomized traffic with live config changes
    for (int c = 0; c < 1500; c++) begin
      @(negedge sys_clk);
      adc_data = 24'($urandom);
      adc_valid = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) begin
        cfg_fmt_in = 1'($urandom); cfg_fmt_out = 1'($urandom);
        cfg_src_sel = 2'($urandom); cfg_mute = 2'($urandom);
        cfg_gain = {3'($urandom_range(7)), 3'($urandom_range(7))};
      end
      sat_clr = ($urandom_range(19) == 0);
      cap_arm = ($urandom_range(19) == 0);
      cap_trig = 1'($urandom);
      cap_ch = 1'($urandom);
      cap_rd_addr = 4'($urandom);
      sys_rst = ($urandom_range(299) == 0);
    end
    @(negedge sys_clk);
    adc_valid = 1'b0; sys_rst = 1'b0; cap_arm = 1'b0; sat_clr = 1'b0;
    repeat (6) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_dac_router.md
ADC_DAC_ROUTER -- requirements
Module: adc_dac_router

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning ADC channel count and DAC channel count (N_CH>=2).
REQ-002 SHALL have parameter ADC_W, default 12, meaning ADC sample width.
REQ-003 SHALL have parameter DAC_W, default 14, meaning DAC sample width (DAC_W>=ADC_W).
REQ-004 SHALL have parameter CAP_DEPTH, default 16, meaning capture buffer depth (power of 2); AW=clog2(CAP_DEPTH), SW=clog2(N_CH).
REQ-005 SHALL have these ports, one clock, with reset asynchronous and active-high:
  sys_clk  in  1  clock
  sys_rst  in  1  async active-high reset
  adc_data  in  N_CH*ADC_W  ADC samples, channel k at [k*ADC_W +: ADC_W]
  adc_valid  in  1  all channels valid this cycle
  cfg_fmt_in  in  1  0=offset-binary, 1=two's complement ADC input
  cfg_fmt_out  in  1  0=offset-binary, 1=two's complement DAC output
  cfg_src_sel  in  N_CH*SW  source ADC channel for each DAC channel
  cfg_gain  in  N_CH*3  left shift 0..7 for each DAC channel
  cfg_mute  in  N_CH  force mid-scale for each DAC channel
  dac_data  out  N_CH*DAC_W  DAC samples
  dac_valid  out  1  dac_data updated this cycle
  sat_flag  out  N_CH  sticky saturation flag for each DAC channel
  sat_clr  in  1  clear all sat_flag bits
  cap_arm  in  1  capture arm pulse
  cap_trig  in  1  0=immediate, 1=zero-crossing rising
  cap_ch  in  SW  DAC channel to capture
  cap_busy  out  1  state ARMED or FILL
  cap_done  out  1  buffer full
  cap_rd_addr  in  AW  read address
  cap_rd_data  out  DAC_W  read data, two's complement

Function
REQ-006 SHALL be a 3-stage pipeline; dac_valid SHALL assert exactly 3 cycles after adc_valid; dac_data SHALL hold between valids.
REQ-007 Stage 1 SHALL register the inputs and convert to signed, inverting the MSB when cfg_fmt_in=0.
REQ-008 Stage 2 SHALL route per cfg_src_sel (values >= N_CH select channel 0), left-justify by DAC_W-ADC_W, then shift left by cfg_gain with saturation to [-2^(DAC_W-1), 2^(DAC_W-1)-1].
REQ-009 A clamp on a valid sample SHALL set that channel's sat_flag; sat_flag SHALL stay set until sat_clr; sat_clr together with a new clamp SHALL leave the flag set.
REQ-010 Stage 3 SHALL replace a muted channel with signed 0 and then invert the MSB when cfg_fmt_out=0.
REQ-011 Config changes SHALL apply to the next sample entering the affected stage; no glitch on held dac_data.
REQ-012 Capture FSM SHALL have states IDLE, ARMED, FILL, DONE.
  - IDLE/DONE + cap_arm -> ARMED; cap_done cleared; write address reset to 0.
  - ARMED: cap_trig=0 triggers on next stage-3 valid; cap_trig=1 triggers on a valid where channel cap_ch is signed >=0 and the previous valid sample was <0.
  - The trigger sample SHALL be written at address 0 -> FILL.
  - FILL: each stage-3 valid writes the pre-format-conversion signed sample of cap_ch, address +1; write of CAP_DEPTH-1 -> DONE.
  - cap_arm in ARMED/FILL SHALL be ignored; cap_ch and cap_trig SHALL be sampled at arm.
REQ-013 cap_busy=1 in ARMED/FILL; cap_done=1 in DONE only.
REQ-014 cap_rd_data SHALL be registered, valid 1 cycle after cap_rd_addr, in any state; reading during FILL SHALL return old or new data with no corruption.
REQ-015 With default parameters, cfg_fmt_in=cfg_fmt_out=0 and gain 0, dac_data SHALL equal the ADC sample << 2.

Reset
REQ-016 sys_rst SHALL clear asynchronously: dac_data=0, dac_valid=0, sat_flag=0, pipeline valids=0, FSM=IDLE, cap_busy=0, cap_done=0, write address=0, cap_rd_data=0, previous-sign register=0.
REQ-017 Capture RAM contents SHALL NOT be reset; reset in mid-FILL SHALL abort to IDLE with no further writes.

Verification
REQ-018 Assert sys_rst mid-stream -> all outputs 0 within the same cycle; first dac_valid 3 cycles after the first post-reset adc_valid.
REQ-019 ch0=0xFFF, fmt_in=0, gain 0: fmt_out=0 -> dac0=0x3FFC; fmt_out=1 -> 0x1FFC; ch0=0x800 -> 0x2000 / 0x0000.
REQ-020 fmt_in=0, gain=1, fmt_out=1: ch0=0xFFF -> 0x1FFF and sat_flag[0]=1; ch0=0x000 -> 0x2000; sat_clr -> flag 0.
REQ-021 src_sel={0,1} (DAC0<-ADC1, DAC1<-ADC0), ch0=0x100, ch1=0xF00, fmt 0/0 -> dac0=0x3C00, dac1=0x0400; mute[1]=1 -> dac1=0x2000.
REQ-022 cap_arm with cap_trig=0, 16 valids of a ramp -> cap_done after 16th, addr k holds sample k; cap_arm during FILL ignored.
REQ-023 cap_trig=1 with a sine on cap_ch -> addr 0 holds the first >=0 sample after a negative one; sys_rst at address 7 -> IDLE, cap_busy=0, cap_done=0.
